uart_gain_rx: RTL

Serial receiver and command parser for run-time PID tuning from the host. It deserializes 8N1 UART bytes on `serial_rx` and assembles fixed-length command frames. On each valid frame it updates one of four holding registers: wall-follower `k_p`, `k_i`, `k_d`, or the diagonal distance setpoint. It is the host-to-board counterpart of the existing telemetry transmit path and sits between the RX pin and the PID gain/setpoint flops.

---
 rtl/uart_gain_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_gain_rx.sv
// UART 8N1 receiver and command parser that writes PID gains and the distance setpoint.
// Define UART_GAIN_RX_CHECKSUM_EN for 5-byte frames with an XOR checksum (default: 4-byte frames).
module uart_gain_rx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int GAIN_WIDTH   = 16,
  parameter int SP_WIDTH     = 7,
  parameter int TIMEOUT_CLKS = 1250000,
  parameter int KP_RESET     = 200,
  parameter int KI_RESET     = 0,
  parameter int KD_RESET     = 0,
  parameter int SP_RESET     = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_rx,
  output logic [GAIN_WIDTH-1:0] k_p,
  output logic [GAIN_WIDTH-1:0] k_i,
  output logic [GAIN_WIDTH-1:0] k_d,
  output logic [SP_WIDTH-1:0]   setpoint,
  output logic                  update,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [31:0]      SP_MAX    = 32'((1 << SP_WIDTH) - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  localparam logic [2:0] P_SYNC = 3'd0;
  localparam logic [2:0] P_ADDR = 3'd1;
  localparam logic [2:0] P_HI   = 3'd2;
  localparam logic [2:0] P_LO   = 3'd3;
`ifdef UART_GAIN_RX_CHECKSUM_EN
  localparam logic [2:0] P_CK   = 3'd4;
  localparam logic [2:0] LO_NEXT = P_CK;
`else
  localparam logic [2:0] LO_NEXT = P_SYNC;
`endif

  function automatic logic [SP_WIDTH-1:0] sat_setpoint(input logic [15:0] w);
    if ({16'd0, w} > SP_MAX)
      return '1;
    else
      return w[SP_WIDTH-1:0];
  endfunction

  logic             rx_s1, rx_s2, rx_prev;
  logic [1:0]       bstate;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_valid, stop_err;
  logic [2:0]       pstate;
  logic [TO_W-1:0]  tcnt;
  logic [1:0]       addr_q;
  logic [7:0]       hi_q;
  logic [15:0]      cmd_word;
  logic             commit_go, ck_fail, addr_bad;

  // Stage: input synchronizer (idle-high line)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= serial_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Stage: bit-level FSM; a start needs a fresh high->low edge, so a low stop bit cannot re-trigger
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bstate     <= B_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (bstate)
        B_IDLE: begin
          if (rx_prev && !rx_s2) begin
            bstate  <= B_START;
            bit_cnt <= '0;
          end
        end
        B_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            bstate  <= rx_s2 ? B_IDLE : B_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7)
              bstate <= B_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt    <= '0;
            bstate     <= B_IDLE;
            byte_valid <= rx_s2;
            stop_err   <= !rx_s2;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // shreg holds the received byte until the next data bit, so it doubles as the byte output
  always_ff @(posedge clk) begin
    if (bstate == B_DATA && bit_cnt == BIT_LAST)
      shreg <= {rx_s2, shreg[7:1]};
  end

  // Stage: frame field capture
  always_ff @(posedge clk) begin
    if (byte_valid && pstate == P_ADDR)
      addr_q <= shreg[1:0];
    if (byte_valid && pstate == P_HI)
      hi_q <= shreg;
  end

`ifdef UART_GAIN_RX_CHECKSUM_EN
  logic [7:0] lo_q;
  logic       ck_ok;

  always_ff @(posedge clk) begin
    if (byte_valid && pstate == P_LO)
      lo_q <= shreg;
  end

  assign cmd_word  = {hi_q, lo_q};
  assign ck_ok     = (shreg == ({6'd0, addr_q} ^ hi_q ^ lo_q));
  assign commit_go = byte_valid && (pstate == P_CK) && ck_ok;
  assign ck_fail   = byte_valid && (pstate == P_CK) && !ck_ok;
`else
  assign cmd_word  = {hi_q, shreg};
  assign commit_go = byte_valid && (pstate == P_LO);
  assign ck_fail   = 1'b0;
`endif

  assign addr_bad = byte_valid && (pstate == P_ADDR) && (shreg > 8'd3);

  // Stage: parser FSM and inter-byte timeout; byte_valid outranks the timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate <= P_SYNC;
      tcnt   <= '0;
    end else if (stop_err) begin
      pstate <= P_SYNC;
      tcnt   <= '0;
    end else if (byte_valid) begin
      tcnt <= '0;
      case (pstate)
        P_SYNC:  if (shreg == SYNC_BYTE) pstate <= P_ADDR;
        P_ADDR:  pstate <= addr_bad ? P_SYNC : P_HI;
        P_HI:    pstate <= P_LO;
        P_LO:    pstate <= LO_NEXT;
        default: pstate <= P_SYNC;
      endcase
    end else if (pstate != P_SYNC) begin
      if (tcnt == TO_LAST) begin
        pstate <= P_SYNC;
        tcnt   <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Stage: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_p       <= GAIN_WIDTH'(KP_RESET);
      k_i       <= GAIN_WIDTH'(KI_RESET);
      k_d       <= GAIN_WIDTH'(KD_RESET);
      setpoint  <= SP_WIDTH'(SP_RESET);
      update    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      update    <= commit_go;
      frame_err <= stop_err | addr_bad | ck_fail;
      if (commit_go) begin
        case (addr_q)
          2'd0:    k_p      <= GAIN_WIDTH'(cmd_word);
          2'd1:    k_i      <= GAIN_WIDTH'(cmd_word);
          2'd2:    k_d      <= GAIN_WIDTH'(cmd_word);
          default: setpoint <= sat_setpoint(cmd_word);
        endcase
      end
    end
  end

endmodule
